// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
// Shared constants, FSM encoding and the double-dabble step function used by
// the bcd_conv_sched slice.
//   BIN_W      operand width (binary in)
//   BCD_DIGITS number of BCD digits kept in the accumulator
//   BCD_W      width of the returned result {hundreds[1:0], tens, ones}
//   DD_ITER    shift-add-3 iterations per conversion (one per operand bit)
// ---------------------------------------------------------------------------
package bcd_pkg;

  localparam int BIN_W      = 8;
  localparam int BCD_DIGITS = 3;
  localparam int BCD_W      = 10;
  localparam int DD_ITER    = 8;
  localparam int ACC_W      = 4 * BCD_DIGITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    RESP = 2'd2
  } state_e;

  // One double-dabble iteration: correct every digit >= 5 by +3, then shift
  // {acc, operand} left by one. Returns the new {acc, operand}.
  function automatic logic [ACC_W+BIN_W-1:0] dd_step(
    input logic [ACC_W-1:0] acc,
    input logic [BIN_W-1:0] op
  );
    logic [ACC_W-1:0] adj;
    adj = acc;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (adj[4*d +: 4] >= 4'd5) adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
    end
    return {adj, op} << 1;
  endfunction

endpackage

// File: rtl/bcd_conv_sched_if.sv
// ---------------------------------------------------------------------------
// bcd_conv_sched_if
// Request/response bus of the shared BCD conversion service.
//   req_valid[NUM_REQ]   per-requester request valid         (master -> slave)
//   req_bin[8*NUM_REQ]   per-requester operand, i at [8i+:8] (master -> slave)
//   req_ready[NUM_REQ]   one-hot accept strobe               (slave -> master)
//   rsp_valid            result valid                        (slave -> master)
//   rsp_ready            result consumer ready               (master -> slave)
//   rsp_bcd[10]          {hundreds[1:0], tens[3:0], ones[3:0]}
//   rsp_id[ID_W]         requester that owns rsp_bcd
// ---------------------------------------------------------------------------
interface bcd_conv_sched_if #(
  parameter int NUM_REQ = 4
) ();
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_bin;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [9:0]           rsp_bcd;
  logic [ID_W-1:0]      rsp_id;

  modport master (
    output req_valid, req_bin, rsp_ready,
    input  req_ready, rsp_valid, rsp_bcd, rsp_id
  );

  modport slave (
    input  req_valid, req_bin, rsp_ready,
    output req_ready, rsp_valid, rsp_bcd, rsp_id
  );
endinterface

// File: rtl/bcd_dd_engine.sv
// ---------------------------------------------------------------------------
// bcd_dd_engine
// Iterative shift-add-3 binary-to-BCD converter, one bit per clock.
//   clk, rst_n  clock, synchronous active-low reset
//   start       load operand, clear accumulator, begin DD_ITER iterations
//   operand     binary input, sampled when start is high
//   done        high during the last iteration cycle
//   bcd         result of the iteration in progress; final while done is high
// ---------------------------------------------------------------------------
module bcd_dd_engine
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] operand,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);
  localparam int CNT_W = $clog2(DD_ITER);

  logic [ACC_W-1:0]       acc_q;
  logic [BIN_W-1:0]       op_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   active_q;
  logic [ACC_W+BIN_W-1:0] step;

  assign step = dd_step(acc_q, op_q);
  assign done = active_q && (cnt_q == CNT_W'(DD_ITER - 1));
  // Upper accumulator bits are always zero for an 8-bit operand.
  assign bcd  = step[BIN_W +: BCD_W];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q    <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (start) begin
      acc_q    <= '0;
      op_q     <= operand;
      cnt_q    <= '0;
      active_q <= 1'b1;
    end else if (active_q) begin
      {acc_q, op_q} <= step;
      if (done) begin
        cnt_q    <= '0;
        active_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end
endmodule

// File: rtl/bcd_conv_sched.sv
// ---------------------------------------------------------------------------
// bcd_conv_sched
// Binary-to-BCD conversion service shared by NUM_REQ requesters. An arbiter
// grants one requester in IDLE, the operand is converted in 8 CONV cycles by
// bcd_dd_engine, and the tagged result is held in RESP until rsp_ready.
//   clk, rst_n  clock, synchronous active-low reset
//   bus         bcd_conv_sched_if.slave (request and response handshakes)
//   busy        high whenever the FSM is not in IDLE
// Build option: define BCD_SCHED_FIXED_PRIO_EN for fixed lowest-index
// priority; the default build uses round-robin starting at requester 0.
// ---------------------------------------------------------------------------
module bcd_conv_sched
  import bcd_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  bcd_conv_sched_if.slave   bus,
  output logic              busy
);
  localparam int ID_W = $clog2(NUM_REQ);

  state_e           state_q;
  logic [ID_W-1:0]  gnt_id_q;
  logic             rsp_valid_q;
  logic [BCD_W-1:0] rsp_bcd_q;
  logic [ID_W-1:0]  rsp_id_q;
  logic             busy_q;
`ifndef BCD_SCHED_FIXED_PRIO_EN
  logic [ID_W-1:0]  rr_q;
`endif

  logic             gnt_found;
  logic [ID_W-1:0]  gnt_idx;
  logic             start;
  logic             eng_done;
  logic [BCD_W-1:0] eng_bcd;

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
`ifdef BCD_SCHED_FIXED_PRIO_EN
    // Scan downward so the lowest set index is the one left standing.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(i);
      end
    end
`else
    // Search upward from the requester after the last one granted, with wrap.
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!gnt_found && bus.req_valid[(int'(rr_q) + k) % NUM_REQ]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'((int'(rr_q) + k) % NUM_REQ);
      end
    end
`endif
  end

  assign start         = (state_q == IDLE) && gnt_found;
  assign bus.req_ready = start ? (NUM_REQ'(1) << gnt_idx) : '0;

  bcd_dd_engine u_engine (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .operand (bus.req_bin[gnt_idx*BIN_W +: BIN_W]),
    .done    (eng_done),
    .bcd     (eng_bcd)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_id_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_bcd_q   <= '0;
      rsp_id_q    <= '0;
      busy_q      <= 1'b0;
`ifndef BCD_SCHED_FIXED_PRIO_EN
      rr_q        <= ID_W'(NUM_REQ - 1);
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_found) begin
            gnt_id_q <= gnt_idx;
            busy_q   <= 1'b1;
            state_q  <= CONV;
`ifndef BCD_SCHED_FIXED_PRIO_EN
            rr_q     <= gnt_idx;
`endif
          end
        end
        CONV: begin
          if (eng_done) begin
            rsp_valid_q <= 1'b1;
            rsp_bcd_q   <= eng_bcd;
            rsp_id_q    <= gnt_id_q;
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_bcd   = rsp_bcd_q;
  assign bus.rsp_id    = rsp_id_q;
  assign busy          = busy_q;
endmodule
